issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, architectural register count; x0 never tracked.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port id_valid  input  1  decoded instruction present in ID.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rs3  input  5 each  source register addresses.
REQ-007 SHALL have ports has_rs1, has_rs2, has_rs3  input  1 each  source-used flags from the decoder.
REQ-008 SHALL have port id_rd  input  5  destination register.
REQ-009 SHALL have port id_reg_write  input  1  instruction writes rd.
REQ-010 SHALL have port id_serialize  input  1  FENCE/SYSTEM instruction requiring an empty pipeline.
REQ-011 SHALL have port flush  input  1  squash the ID instruction this cycle.
REQ-012 SHALL have ports wb_valid  input  1, wb_rd  input  5  writeback retiring a pending write.
REQ-013 SHALL have port serial_done  input  1  single-cycle pulse: serialized instruction completed.
REQ-014 SHALL have port issue  output  1  ID instruction accepted this cycle.
REQ-015 SHALL have port stall  output  1  id_valid held because of a hazard or FSM state.
REQ-016 SHALL have port busy  output  REG_NUM  pending-write bit vector; bit 0 always 0.
REQ-017 SHALL have port outstanding  output  6  count of set busy bits.
REQ-018 SHALL have port state  output  2  FSM state: RUN=0, DRAIN=1, SERIAL=2.
REQ-019 SHALL have port err_spurious  output  1  sticky: writeback to a non-busy register.
REQ-020 SHALL have port stall_cycles  output  STALL_CNT_W  saturating count of stall cycles.

Function
REQ-021 SHALL compute eff_busy = busy with bit wb_rd cleared when wb_valid (same-cycle writeback bypass).
REQ-022 SHALL raise hazard when any used source (has_rsN, rsN != 0) hits eff_busy, or id_reg_write && id_rd != 0 && eff_busy[id_rd] (WAW).
REQ-023 SHALL assert issue combinationally = id_valid && !flush && !hazard && ((state==RUN && !(id_serialize && outstanding_next_wb != 0)) || (state==DRAIN && outstanding_next_wb == 0)), where outstanding_next_wb = outstanding minus a valid wb retire.
REQ-024 SHALL assert stall = id_valid && !flush && !issue.
REQ-025 SHALL set busy[id_rd] next cycle on issue with id_reg_write && id_rd != 0; clear busy[wb_rd] on wb_valid && wb_rd != 0 && busy[wb_rd]; set wins if both target one register.
REQ-026 SHALL update outstanding: +1 on set, -1 on valid clear, unchanged when both or neither occur; it always equals popcount(busy).
REQ-027 SHALL set err_spurious (sticky until reset) on wb_valid with wb_rd != 0 and busy[wb_rd]==0; busy and outstanding unchanged by that writeback.
REQ-028 SHALL ignore wb_valid with wb_rd==0 entirely.
REQ-029 FSM RUN: id_valid && id_serialize && !flush && outstanding_next_wb != 0 -> DRAIN (no issue); serialize issuing -> SERIAL.
REQ-030 FSM DRAIN: serialize issues when outstanding_next_wb==0 -> SERIAL; flush -> RUN.
REQ-031 FSM SERIAL: no instruction issues; serial_done -> RUN next cycle; flush does not leave SERIAL.
REQ-032 SHALL ignore serial_done outside SERIAL.
REQ-033 SHALL increment stall_cycles on each cycle stall==1, saturating at all-ones.
REQ-034 flush SHALL suppress issue and stall in the same cycle and leave busy untouched except for that cycle's writeback.

Reset
REQ-035 On clk edge with rst_n==0: busy=0, outstanding=0, state=RUN, err_spurious=0, stall_cycles=0; writebacks and issues that cycle are discarded.
REQ-036 Reset mid-DRAIN or mid-SERIAL SHALL return to RUN with empty scoreboard the next cycle.

Verification
REQ-037 RAW: issue rd=5 write; next cycle rs1=5 has_rs1=1 -> stall=1, issue=0; wb_valid wb_rd=5 same cycle -> issue=1 (bypass), busy[5] cleared.
REQ-038 WAW/set-wins: busy[7]=1, wb_rd=7 and new issue rd=7 same cycle -> busy[7]=1, outstanding unchanged.
REQ-039 Serialize: outstanding=2, FENCE in ID -> state DRAIN, stall=1 until two writebacks; issue on the retire of the last, state SERIAL; serial_done -> RUN; stall_cycles increments per held cycle.
REQ-040 Spurious/x0: wb_rd=9 with busy[9]=0 -> err_spurious=1, outstanding unchanged; issue rd=0 reg_write -> busy stays 0.
REQ-041 Fill: 31 issues to x1..x31 without writeback -> outstanding=31, busy=0xFFFFFFFE; rst_n=0 one cycle -> all outputs zero, state RUN.
REQ-042 Flush in DRAIN -> state RUN next cycle, issue=0, stall=0 that cycle.

Source files
------------

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: pending-write scoreboard with RAW/WAW hazard detection and serialize FSM
module issue_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [4:0]             id_rs3,
  input  logic                   has_rs1,
  input  logic                   has_rs2,
  input  logic                   has_rs3,
  input  logic [4:0]             id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_serialize,
  input  logic                   flush,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   serial_done,
  output logic                   issue,
  output logic                   stall,
  output logic [REG_NUM-1:0]     busy,
  output logic [5:0]             outstanding,
  output logic [1:0]             state,
  output logic                   err_spurious,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SERIAL = 2'd2} state_t;
  state_t st;
  logic [REG_NUM-1:0] wb_mask, eff_busy, set_mask;
  logic [5:0] ond;
  logic wb_hit, wb_clr, hazard, set;
  assign state = st;
  always_comb begin
    wb_mask = wb_valid ? REG_NUM'(1) << wb_rd : '0;
    eff_busy = busy & ~wb_mask;
    wb_hit = wb_valid && wb_rd != 5'd0;
    wb_clr = wb_hit && busy[wb_rd];
    ond = outstanding - 6'(wb_clr);
    hazard = (has_rs1 && id_rs1 != 5'd0 && eff_busy[id_rs1]) ||
             (has_rs2 && id_rs2 != 5'd0 && eff_busy[id_rs2]) ||
             (has_rs3 && id_rs3 != 5'd0 && eff_busy[id_rs3]) ||
             (id_reg_write && id_rd != 5'd0 && eff_busy[id_rd]);
    issue = id_valid && !flush && !hazard &&
            ((st == RUN && !(id_serialize && ond != 6'd0)) || (st == DRAIN && ond == 6'd0));
    stall = id_valid && !flush && !issue;
    set = issue && id_reg_write && id_rd != 5'd0;
    set_mask = set ? REG_NUM'(1) << id_rd : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
      outstanding <= '0;
      st <= RUN;
      err_spurious <= 1'b0;
      stall_cycles <= '0;
    end else begin
      busy <= (busy & ~(wb_clr ? wb_mask : '0)) | set_mask;
      outstanding <= outstanding + 6'(set) - 6'(wb_clr);
      if (wb_hit && !busy[wb_rd]) err_spurious <= 1'b1;
      if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      st <= st == RUN    ? (issue && id_serialize ? SERIAL :
                            id_valid && id_serialize && !flush && ond != 6'd0 ? DRAIN : RUN) :
            st == DRAIN  ? (flush ? RUN : issue ? SERIAL : DRAIN) :
            st == SERIAL ? (serial_done ? RUN : SERIAL) : RUN;
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scenarios plus randomized run against a behavioural scoreboard model
module tb_issue_scoreboard;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, has_rs1, has_rs2, has_rs3, id_reg_write, id_serialize, flush, wb_valid, serial_done;
  logic [4:0] id_rs1, id_rs2, id_rs3, id_rd, wb_rd;
  logic issue, stall, err_spurious;
  logic [31:0] busy;
  logic [5:0] outstanding;
  logic [1:0] state;
  logic [15:0] stall_cycles;
  int tests = 0, fails = 0;
  issue_scoreboard #(.REG_NUM(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .has_rs1(has_rs1), .has_rs2(has_rs2), .has_rs3(has_rs3),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_serialize(id_serialize),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .serial_done(serial_done),
    .issue(issue), .stall(stall), .busy(busy), .outstanding(outstanding),
    .state(state), .err_spurious(err_spurious), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    id_valid = 0; has_rs1 = 0; has_rs2 = 0; has_rs3 = 0; id_reg_write = 0; id_serialize = 0;
    flush = 0; wb_valid = 0; serial_done = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs3 = 0; id_rd = 0; wb_rd = 0;
  endtask
  task automatic issue_write(input logic [4:0] rd);
    idle;
    id_valid = 1; id_reg_write = 1; id_rd = rd;
  endtask
  task automatic test_reset;
    idle;
    rst_n = 0;
    tick;
    tick;
    rst_n = 1;
    #1;
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL reset_busy got %h exp %h", busy, 32'h0); end
    tests++; if (outstanding !== 6'd0) begin fails++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", state); end
    tests++; if (err_spurious !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err_spurious); end
    tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
    tests++; if ({issue, stall} !== 2'b00) begin fails++; $display("FAIL reset_issue_stall got %b exp 00", {issue, stall}); end
  endtask
  task automatic test_raw;
    issue_write(5);
    #1;
    tests++; if (issue !== 1'b1) begin fails++; $display("FAIL raw_first_issue got %b exp 1", issue); end
    tick;
    tests++; if (busy !== 32'h20) begin fails++; $display("FAIL raw_busy_set got %h exp %h", busy, 32'h20); end
    idle;
    id_valid = 1; id_rs1 = 5; has_rs1 = 1;
    #1;
    tests++; if ({issue, stall} !== 2'b01) begin fails++; $display("FAIL raw_stall got issue/stall %b exp 01", {issue, stall}); end
    tick;
    wb_valid = 1; wb_rd = 5;
    #1;
    tests++; if ({issue, stall} !== 2'b10) begin fails++; $display("FAIL raw_bypass got issue/stall %b exp 10", {issue, stall}); end
    tick;
    tests++; if (busy !== 32'h0 || outstanding !== 6'd0) begin fails++; $display("FAIL raw_clear got busy %h outst %0d exp 0 0", busy, outstanding); end
    tests++; if (stall_cycles !== 16'd1) begin fails++; $display("FAIL raw_stall_cycles got %0d exp 1", stall_cycles); end
    idle;
  endtask
  task automatic test_waw;
    issue_write(7);
    tick;
    issue_write(7);
    wb_valid = 1; wb_rd = 7;
    #1;
    tests++; if (issue !== 1'b1) begin fails++; $display("FAIL waw_issue got %b exp 1", issue); end
    tick;
    tests++; if (busy !== 32'h80 || outstanding !== 6'd1) begin fails++; $display("FAIL waw_set_wins got busy %h outst %0d exp 80 1", busy, outstanding); end
    idle;
    wb_valid = 1; wb_rd = 7;
    tick;
    tests++; if (busy !== 32'h0 || outstanding !== 6'd0) begin fails++; $display("FAIL waw_retire got busy %h outst %0d exp 0 0", busy, outstanding); end
    idle;
  endtask
  task automatic test_serialize;
    logic [15:0] sc0;
    issue_write(3);
    tick;
    issue_write(4);
    tick;
    tests++; if (outstanding !== 6'd2) begin fails++; $display("FAIL ser_outstanding got %0d exp 2", outstanding); end
    sc0 = stall_cycles;
    idle;
    id_valid = 1; id_serialize = 1;
    #1;
    tests++; if ({issue, stall} !== 2'b01) begin fails++; $display("FAIL ser_hold got issue/stall %b exp 01", {issue, stall}); end
    tick;
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL ser_drain_state got %0d exp 1", state); end
    wb_valid = 1; wb_rd = 3;
    #1;
    tests++; if ({issue, stall} !== 2'b01) begin fails++; $display("FAIL ser_drain_one got issue/stall %b exp 01", {issue, stall}); end
    tick;
    wb_rd = 4;
    #1;
    tests++; if ({issue, stall} !== 2'b10) begin fails++; $display("FAIL ser_last_retire got issue/stall %b exp 10", {issue, stall}); end
    tick;
    tests++; if (state !== 2'd2 || outstanding !== 6'd0) begin fails++; $display("FAIL ser_serial_state got st %0d outst %0d exp 2 0", state, outstanding); end
    tests++; if (stall_cycles !== sc0 + 16'd2) begin fails++; $display("FAIL ser_stall_cycles got %0d exp %0d", stall_cycles, sc0 + 16'd2); end
    idle;
    id_valid = 1;
    #1;
    tests++; if ({issue, stall} !== 2'b01) begin fails++; $display("FAIL ser_no_issue got issue/stall %b exp 01", {issue, stall}); end
    tick;
    flush = 1;
    tick;
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL ser_flush_stays got %0d exp 2", state); end
    idle;
    serial_done = 1;
    tick;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL ser_done_run got %0d exp 0", state); end
    idle;
  endtask
  task automatic test_spurious;
    wb_valid = 1; wb_rd = 0;
    tick;
    tests++; if (err_spurious !== 1'b0) begin fails++; $display("FAIL x0_wb_ignored got %b exp 0", err_spurious); end
    wb_rd = 9;
    tick;
    tests++; if (err_spurious !== 1'b1 || outstanding !== 6'd0) begin fails++; $display("FAIL spurious got err %b outst %0d exp 1 0", err_spurious, outstanding); end
    issue_write(0);
    tick;
    tests++; if (busy !== 32'h0 || outstanding !== 6'd0) begin fails++; $display("FAIL x0_write got busy %h outst %0d exp 0 0", busy, outstanding); end
    tests++; if (err_spurious !== 1'b1) begin fails++; $display("FAIL spurious_sticky got %b exp 1", err_spurious); end
    idle;
  endtask
  task automatic test_flush_drain;
    issue_write(2);
    tick;
    idle;
    id_valid = 1; id_serialize = 1;
    tick;
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL fd_drain got %0d exp 1", state); end
    flush = 1;
    #1;
    tests++; if ({issue, stall} !== 2'b00) begin fails++; $display("FAIL fd_flush got issue/stall %b exp 00", {issue, stall}); end
    tick;
    tests++; if (state !== 2'd0 || busy !== 32'h4) begin fails++; $display("FAIL fd_run got st %0d busy %h exp 0 4", state, busy); end
    idle;
    wb_valid = 1; wb_rd = 2;
    tick;
    idle;
  endtask
  task automatic test_fill;
    for (int r = 1; r < 32; r++) begin
      issue_write(5'(r));
      tick;
    end
    idle;
    tests++; if (outstanding !== 6'd31 || busy !== 32'hFFFF_FFFE) begin fails++; $display("FAIL fill got busy %h outst %0d exp fffffffe 31", busy, outstanding); end
    rst_n = 0;
    tick;
    rst_n = 1;
    tests++; if (busy !== 32'h0 || outstanding !== 6'd0 || state !== 2'd0 || err_spurious !== 1'b0 || stall_cycles !== 16'd0) begin
      fails++; $display("FAIL fill_reset got busy %h outst %0d st %0d err %b sc %0d exp all 0", busy, outstanding, state, err_spurious, stall_cycles);
    end
  endtask
  task automatic test_random;
    bit mb[32];
    int mst, msc, cnt, ond;
    bit merr, haz, eiss, estall, retire;
    logic [31:0] ebusy;
    idle;
    rst_n = 0;
    tick;
    rst_n = 1;
    foreach (mb[i]) mb[i] = 0;
    mst = 0; msc = 0; merr = 0;
    for (int c = 0; c < 600; c++) begin
      idle;
      rst_n = ($urandom_range(0, 79) != 0);
      id_valid = ($urandom_range(0, 9) < 7);
      id_rs1 = 5'($urandom_range(0, 7)); has_rs1 = 1'($urandom);
      id_rs2 = 5'($urandom_range(0, 7)); has_rs2 = 1'($urandom);
      id_rs3 = 5'($urandom_range(0, 7)); has_rs3 = 1'($urandom);
      id_rd = 5'($urandom_range(0, 7)); id_reg_write = 1'($urandom);
      id_serialize = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 7) == 0);
      wb_valid = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 7));
      serial_done = ($urandom_range(0, 3) == 0);
      if (mst == 1) begin
        id_valid = 1; id_serialize = 1; id_reg_write = 0;
        has_rs1 = 0; has_rs2 = 0; has_rs3 = 0;
      end
      cnt = 0;
      foreach (mb[i]) cnt += mb[i];
      retire = wb_valid && wb_rd != 0 && mb[wb_rd];
      ond = cnt - int'(retire);
      haz = 0;
      if (has_rs1 && id_rs1 != 0 && mb[id_rs1] && !(wb_valid && wb_rd == id_rs1)) haz = 1;
      if (has_rs2 && id_rs2 != 0 && mb[id_rs2] && !(wb_valid && wb_rd == id_rs2)) haz = 1;
      if (has_rs3 && id_rs3 != 0 && mb[id_rs3] && !(wb_valid && wb_rd == id_rs3)) haz = 1;
      if (id_reg_write && id_rd != 0 && mb[id_rd] && !(wb_valid && wb_rd == id_rd)) haz = 1;
      eiss = id_valid && !flush && !haz &&
             ((mst == 0 && !(id_serialize && ond != 0)) || (mst == 1 && ond == 0));
      estall = id_valid && !flush && !eiss;
      #1;
      if (rst_n) begin
        tests++; if (issue !== eiss) begin fails++; $display("FAIL rnd_issue cyc %0d got %b exp %b", c, issue, eiss); end
        tests++; if (stall !== estall) begin fails++; $display("FAIL rnd_stall cyc %0d got %b exp %b", c, stall, estall); end
      end
      if (!rst_n) begin
        foreach (mb[i]) mb[i] = 0;
        mst = 0; msc = 0; merr = 0;
      end else begin
        if (wb_valid && wb_rd != 0 && !mb[wb_rd]) merr = 1;
        if (retire) mb[wb_rd] = 0;
        if (eiss && id_reg_write && id_rd != 0) mb[id_rd] = 1;
        if (estall && msc < 65535) msc++;
        case (mst)
          0: mst = (eiss && id_serialize) ? 2 : (id_valid && id_serialize && !flush && ond != 0) ? 1 : 0;
          1: mst = flush ? 0 : eiss ? 2 : 1;
          default: mst = serial_done ? 0 : 2;
        endcase
      end
      tick;
      ebusy = '0;
      cnt = 0;
      foreach (mb[i]) begin
        ebusy[i] = mb[i];
        cnt += mb[i];
      end
      tests++; if (busy !== ebusy) begin fails++; $display("FAIL rnd_busy cyc %0d got %h exp %h", c, busy, ebusy); end
      tests++; if (outstanding !== 6'(cnt)) begin fails++; $display("FAIL rnd_outstanding cyc %0d got %0d exp %0d", c, outstanding, cnt); end
      tests++; if (state !== 2'(mst)) begin fails++; $display("FAIL rnd_state cyc %0d got %0d exp %0d", c, state, mst); end
      tests++; if (err_spurious !== merr) begin fails++; $display("FAIL rnd_err cyc %0d got %b exp %b", c, err_spurious, merr); end
      tests++; if (stall_cycles !== 16'(msc)) begin fails++; $display("FAIL rnd_stall_cycles cyc %0d got %0d exp %0d", c, stall_cycles, msc); end
    end
    idle;
  endtask
  initial begin
    idle;
    test_reset;
    test_raw;
    test_waw;
    test_serialize;
    test_spurious;
    test_flush_drain;
    test_fill;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
